// File: rtl/wave_counter_pkg.sv
// wave_counter_pkg: direction decode and count-width helper shared by wave_counter and its instantiators
package wave_counter_pkg;
  typedef enum logic [1:0] {HOLD, UP, DOWN} dir_e;
  function automatic int count_width(input int max_val);
    return ($clog2(max_val + 1) > 1) ? $clog2(max_val + 1) : 1;
  endfunction
  function automatic dir_e decode_dir(input logic up, input logic down);
    return (up == down) ? HOLD : (up ? UP : DOWN);
  endfunction
endpackage

// File: rtl/wave_counter.sv
// wave_counter: modulo-(max_val_p+1) up/down counter; wrap_o exists only with WAVE_COUNTER_WRAP_PULSE_EN
module wave_counter
  import wave_counter_pkg::*;
#(
  parameter int max_val_p   = 99,
  parameter int reset_val_p = 0,
  localparam int width_lp   = count_width(max_val_p)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
  ,
  output logic                wrap_o
`endif
);
  if (max_val_p < 1) begin : g_bad_max
    $error("wave_counter: max_val_p must be at least 1");
  end
  if (reset_val_p < 0 || reset_val_p > max_val_p) begin : g_bad_reset
    $error("wave_counter: reset_val_p must lie in 0..max_val_p");
  end
  localparam logic [width_lp-1:0] max_c   = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] reset_c = width_lp'(reset_val_p);
  dir_e                dir;
  logic                at_max, at_zero;
  logic [width_lp-1:0] count_next;
  // Wrap is decided before the +1/-1 so no intermediate ever exceeds max_val_p
  always_comb begin
    dir        = decode_dir(up_i, down_i);
    at_max     = count_o == max_c;
    at_zero    = count_o == '0;
    count_next = (dir == UP)   ? (at_max  ? '0    : count_o + width_lp'(1)) :
                 (dir == DOWN) ? (at_zero ? max_c : count_o - width_lp'(1)) : count_o;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) count_o <= reset_c;
    else count_o <= count_next;
  end
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_ni) wrap_o <= 1'b0;
    else wrap_o <= (dir == UP && at_max) || (dir == DOWN && at_zero);
  end
`endif
endmodule

// File: tb/tb_wave_counter.sv
// tb_wave_counter: randomized and directed scoreboard bench for two wave_counter configurations
module tb_wave_counter;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0, up_i = 1'b0, down_i = 1'b0;
  logic [6:0] count99;
  logic [2:0] count5;
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
  logic wrap99, wrap5;
`endif
  int checks = 0, failures = 0;
  int m99 = 0, m5 = 3;
  typedef struct {int c99; int c5; bit w99; bit w5;} exp_t;
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  wave_counter #(.max_val_p(99), .reset_val_p(0)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .up_i(up_i), .down_i(down_i), .count_o(count99)
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
    , .wrap_o(wrap99)
`endif
  );
  wave_counter #(.max_val_p(5), .reset_val_p(3)) dut5 (
    .clk_i(clk_i), .reset_ni(reset_ni), .up_i(up_i), .down_i(down_i), .count_o(count5)
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
    , .wrap_o(wrap5)
`endif
  );

  // Reference: a modular counter in plain integer arithmetic
  task automatic step(input bit r_n, input bit u, input bit d);
    exp_t e;
    @(negedge clk_i);
    reset_ni = r_n; up_i = u; down_i = d;
    e.w99 = r_n && ((u && !d && m99 == 99) || (d && !u && m99 == 0));
    e.w5  = r_n && ((u && !d && m5 == 5) || (d && !u && m5 == 0));
    if (!r_n) begin
      m99 = 0; m5 = 3;
    end else if (u && !d) begin
      m99 = (m99 + 1) % 100; m5 = (m5 + 1) % 6;
    end else if (d && !u) begin
      m99 = (m99 + 99) % 100; m5 = (m5 + 5) % 6;
    end
    e.c99 = m99; e.c5 = m5;
    q.push_back(e);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 2;
      if (int'(count99) != e.c99) begin
        failures++;
        $display("FAIL count99 got=%0d want=%0d t=%0t", count99, e.c99, $time);
      end
      if (int'(count5) != e.c5) begin
        failures++;
        $display("FAIL count5 got=%0d want=%0d t=%0t", count5, e.c5, $time);
      end
`ifdef WAVE_COUNTER_WRAP_PULSE_EN
      checks += 2;
      if (wrap99 !== e.w99) begin
        failures++;
        $display("FAIL wrap99 got=%b want=%b t=%0t", wrap99, e.w99, $time);
      end
      if (wrap5 !== e.w5) begin
        failures++;
        $display("FAIL wrap5 got=%b want=%b t=%0t", wrap5, e.w5, $time);
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (100) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b1);
    repeat (55) step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom));
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk_i);
      budget++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_counter.md
WAVE_COUNTER -- requirements
Module: wave_counter

Interface
REQ-001 The block SHALL have parameter max_val_p, default 99, giving the highest count value; legal range is 1 or greater.
REQ-002 The block SHALL have parameter reset_val_p, default 0, giving the count loaded at reset; legal range is 0 to max_val_p.
REQ-003 The block SHALL derive localparam width_lp = max(1, $clog2(max_val_p+1)).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port up_i, input, 1 bit: increment request for this cycle.
REQ-007 The block SHALL have port down_i, input, 1 bit: decrement request for this cycle.
REQ-008 The block SHALL have port count_o, output, width_lp bits: the registered current count.
REQ-009 The block SHALL have port wrap_o, output, 1 bit: registered wrap pulse; this port exists only when the macro in REQ-021 is defined.

Function
REQ-010 count_o SHALL be driven directly from a flop, with no combinational path from any input to count_o.
REQ-011 When up_i=1 and down_i=0, the count SHALL go to count+1 on the next edge; at max_val_p it SHALL wrap to 0.
REQ-012 When down_i=1 and up_i=0, the count SHALL go to count-1 on the next edge; at 0 it SHALL wrap to max_val_p.
REQ-013 When up_i and down_i are both 0, or both 1, the count SHALL hold its value.
REQ-014 The count SHALL never hold a value above max_val_p, including when max_val_p+1 is not a power of two; no intermediate value may overflow width_lp.
REQ-015 Latency SHALL be exactly one cycle from a request at an edge to the updated count_o.
REQ-016 There SHALL be no handshake: every request cycle is accepted, and the block never stalls.
REQ-017 When max_val_p=1, the count SHALL toggle between 0 and 1 on any single up or down request.

Reset
REQ-018 When reset_ni=0 at a rising edge, count_o SHALL become reset_val_p, and wrap_o (if present) SHALL become 0.
REQ-019 Reset SHALL take priority over up_i and down_i in the same cycle; reset asserted mid-count SHALL discard the pending request.
REQ-020 In the first cycle after reset_ni rises, the block SHALL respond to requests normally.

Configuration
REQ-021 Macro WAVE_COUNTER_WRAP_PULSE_EN SHALL control the wrap pulse.
- When defined, wrap_o SHALL pulse high for exactly one cycle, coincident with count_o after each wrap (max_val_p to 0 going up, or 0 to max_val_p going down).
- When undefined, the wrap_o port and its logic SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-022 Shared package wave_counter_pkg SHALL hold:
- the direction enum typedef (HOLD, UP, DOWN), decoded from up_i and down_i;
- a constant function count_width(max_val) implementing REQ-003, so instantiating modules can size their count nets.
REQ-023 The block SHALL have no sub-modules: a single registered counter with next-state logic.
REQ-024 The block SHALL contain elaboration-time checks that fail when max_val_p<1 or reset_val_p>max_val_p.

Verification
REQ-025 Reset with max_val_p=99 (width 7): hold reset_ni=0 with up_i=1 for 3 cycles -> count_o=0 throughout and after release.
REQ-026 Up wrap with max_val_p=99: up_i=1 for 100 cycles from 0 -> counts 1..99 then 0; wrap_o=1 only on the 0 cycle (macro on).
REQ-027 Down wrap with max_val_p=99: from 0, down_i=1 for 1 cycle -> 99; then 2 more cycles -> 97.
REQ-028 Hold with max_val_p=99: at count 42, up_i=down_i=1 for 5 cycles, then 0/0 for 5 cycles -> count_o stays 42.
REQ-029 Mid-count reset with max_val_p=5, reset_val_p=3: count to 4, assert reset_ni=0 with up_i=1 -> count 3 next cycle.
REQ-030 Build the bench once without WAVE_COUNTER_WRAP_PULSE_EN -> no wrap_o port, and REQ-026 counts still pass.
